// File: rtl/spi_slave_engine.sv
// -----------------------------------------------------------------------------
// spi_slave_engine
//
// SPI slave-side transfer engine. SCK_in, SS_n and MOSI are oversampled on clk
// through SYNC_STAGES flops. Sample and shift strobes are derived from the
// CPOL/CPHA pair latched at selection. DATA_WIDTH-bit frames are shifted
// MSB-first in both directions, and each completed receive word is handed out
// with a one-cycle rx_valid pulse.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   CPOL, CPHA      SPI mode, latched when SS_n is seen falling
//   SCK_in, SS_n,   asynchronous SPI pins (SS_n active-low)
//   MOSI
//   MISO, MISO_oe   serial data out, driven only while selected
//   tx_data,        transmit holding register write port
//   tx_load,
//   tx_ready
//   rx_data,        last complete received frame and its update pulse
//   rx_valid
//   busy            high while the engine is in the ACTIVE state
//
// Transmit handshake: tx_ready=1 means the holding register is empty. A word
// is transferred on any cycle where tx_load=1 and tx_ready=1, and tx_ready
// then drops. tx_load while tx_ready=0 is dropped, not queued. rx_valid is a
// strobe with no back-pressure.
// -----------------------------------------------------------------------------
module spi_slave_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  SCK_in,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    // Synchronizers and edge-detect history.
    logic [SYNC_STAGES-1:0] sck_pipe;
    logic [SYNC_STAGES-1:0] ss_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sck_d;
    logic                   ss_d;

    logic sck_sync;
    logic ss_sync;
    logic mosi_sync;

    // Mode latched at selection.
    logic cpol_q;
    logic cpha_q;

    // Data path.
    logic [DATA_WIDTH-1:0] tx_hold;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  first_shift;

    // Strobes.
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_edge;
    logic                  shift_edge;
    logic                  start;
    logic                  stop;
    logic                  last_bit;
    logic                  skip_shift;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] tx_reload;

    assign sck_sync  = sck_pipe[SYNC_STAGES-1];
    assign ss_sync   = ss_pipe[SYNC_STAGES-1];
    assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

    always_comb begin
        sck_rise    = sck_sync & ~sck_d;
        sck_fall    = ~sck_sync & sck_d;
        lead_edge   = cpol_q ? sck_fall : sck_rise;
        trail_edge  = cpol_q ? sck_rise : sck_fall;
        // Deselection has priority over any SCK edge seen in the same cycle.
        sample_edge = (state == ACTIVE) && !ss_sync && (cpha_q ? trail_edge : lead_edge);
        shift_edge  = (state == ACTIVE) && !ss_sync && (cpha_q ? lead_edge : trail_edge);
        start       = (state == IDLE) && ss_d && !ss_sync;
        stop        = (state == ACTIVE) && ss_sync;
        last_bit    = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
        // The first shift edge after a (re)load must not shift: for CPHA=1 the
        // MSB is already on the wire, for CPHA=0 this is the trailing edge that
        // follows the reload on the final sample. In the CPHA=0 opening frame
        // the first shift edge arrives with bit_cnt=1, so it shifts normally.
        skip_shift  = first_shift && (bit_cnt == '0);
        rx_next     = {rx_shift[DATA_WIDTH-2:0], mosi_sync};
        tx_reload   = tx_ready ? '0 : tx_hold;
    end

    // Synchronizers. SS_n resets to the deselected level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_pipe  <= '0;
            ss_pipe   <= '1;
            mosi_pipe <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], SCK_in};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], SS_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
            sck_d     <= sck_sync;
            ss_d      <= ss_sync;
        end
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACTIVE;
            ACTIVE:  if (stop)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        busy    = (state == ACTIVE);
        MISO_oe = (state == ACTIVE);
        MISO    = (state == ACTIVE) ? tx_shift[DATA_WIDTH-1] : 1'b0;
    end

    // Data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            tx_hold     <= '0;
            tx_ready    <= 1'b1;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            bit_cnt     <= '0;
            first_shift <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (start) begin
                cpol_q      <= CPOL;
                cpha_q      <= CPHA;
                tx_shift    <= tx_reload;
                tx_ready    <= 1'b1;
                bit_cnt     <= '0;
                rx_shift    <= '0;
                first_shift <= 1'b1;
            end else if (stop) begin
                // Partial frame is dropped.
                bit_cnt <= '0;
            end else if (sample_edge) begin
                rx_shift <= rx_next;
                if (last_bit) begin
                    rx_data     <= rx_next;
                    rx_valid    <= 1'b1;
                    bit_cnt     <= '0;
                    tx_shift    <= tx_reload;
                    tx_ready    <= 1'b1;
                    first_shift <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (shift_edge) begin
                first_shift <= 1'b0;
                if (!skip_shift) begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end

            // Evaluated against the pre-edge tx_ready, so a load in the same
            // cycle that consumes a full holding register is dropped.
            if (tx_load && tx_ready) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_engine.sv
module tb_spi_slave_engine;
  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int HP   = 8;  // SCK half period in clk cycles

  logic         clk = 1'b0;
  logic         rst;
  logic         CPOL;
  logic         CPHA;
  logic         SCK_in;
  logic         SS_n;
  logic         MOSI;
  logic         MISO;
  logic         MISO_oe;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  logic miso_stable_ok;

  logic [W-1:0] rx_exp_q[$];
  logic [W-1:0] miso_exp_q[$];

  spi_slave_engine #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .CPOL     (CPOL),
    .CPHA     (CPHA),
    .SCK_in   (SCK_in),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .MISO_oe  (MISO_oe),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_valid pulse pops one expected word.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      checks++;
      assert (rx_exp_q.size() > 0) else begin
        failures++;
        $error("FAIL rx_unexpected: observed=%0h expected=no_pulse", rx_data);
      end
      if (rx_exp_q.size() > 0) check("rx_word", rx_data, rx_exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [W-1:0] v);
    tx_data = v;
    tx_load = 1'b1;
    clks(1);
    tx_load = 1'b0;
  endtask

  task automatic ss_assert(input logic cp, input logic ch);
    CPOL   = cp;
    CPHA   = ch;
    SCK_in = cp;
    clks(4);
    SS_n = 1'b0;
    clks(HP);
  endtask

  task automatic ss_release();
    SS_n = 1'b1;
    clks(SYNC + 2);
  endtask

  // Master side: drives nbits from mosi_bits (MSB first), captures MISO at
  // every sample edge and checks MISO did not move just before that edge.
  task automatic xfer(input int nbits, input logic [15:0] mosi_bits, output logic [15:0] miso_bits);
    logic a;
    logic b;
    logic bo;
    miso_bits = '0;
    for (int i = 0; i < nbits; i++) begin
      bo = mosi_bits[nbits-1-i];
      if (!CPHA) begin
        MOSI = bo;
        clks(HP - 2); a = MISO;
        clks(2);      b = MISO;
        SCK_in = ~CPOL;          // leading = sample
        miso_bits = {miso_bits[14:0], b};
        clks(HP);
        SCK_in = CPOL;           // trailing = shift
      end else begin
        SCK_in = ~CPOL;          // leading = shift
        MOSI = bo;
        clks(HP - 2); a = MISO;
        clks(2);      b = MISO;
        SCK_in = CPOL;           // trailing = sample
        miso_bits = {miso_bits[14:0], b};
        clks(HP);
      end
      if (a !== b) miso_stable_ok = 1'b0;
    end
    if (!CPHA) clks(HP);
  endtask

  task automatic full_frame(input logic cp, input logic ch, input logic [W-1:0] mosi_w,
                            input logic [W-1:0] miso_w, input string tag);
    logic [15:0] got;
    int rx0;
    rx_exp_q.push_back(mosi_w);
    miso_exp_q.push_back(miso_w);
    rx0 = rx_cnt;
    miso_stable_ok = 1'b1;
    ss_assert(cp, ch);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_oe"}, MISO_oe, 1);
    check({tag, "_ready_after_start"}, tx_ready, 1);
    xfer(W, {8'h00, mosi_w}, got);
    ss_release();
    check({tag, "_miso_word"}, got[7:0], miso_exp_q.pop_front());
    check({tag, "_rx_pulses"}, rx_cnt - rx0, 1);
    check({tag, "_rx_data"}, rx_data, mosi_w);
    check({tag, "_miso_stable"}, miso_stable_ok, 1);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    logic [15:0] got16;
    int rx0;
    logic [W-1:0] rt;
    logic [W-1:0] rm;
    int md;

    // Reset
    rst = 1'b1; CPOL = 1'b0; CPHA = 1'b0; SCK_in = 1'b0; SS_n = 1'b1;
    MOSI = 1'b0; tx_load = 1'b0; tx_data = '0;
    clks(4);
    check("rst_miso", MISO, 0);
    check("rst_oe", MISO_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    clks(2);

    // Mode 0: tx 0xA5, master sends 0x3C
    load_tx(8'hA5);
    check("m0_ready_after_load", tx_ready, 0);
    full_frame(1'b0, 1'b0, 8'h3C, 8'hA5, "m0");

    // Modes 1..3: tx 0x81, master sends 0x7E
    load_tx(8'h81);
    full_frame(1'b0, 1'b1, 8'h7E, 8'h81, "m1");
    load_tx(8'h81);
    full_frame(1'b1, 1'b0, 8'h7E, 8'h81, "m2");
    load_tx(8'h81);
    full_frame(1'b1, 1'b1, 8'h7E, 8'h81, "m3");

    // Back-to-back frames under one selection
    load_tx(8'h11);
    rx0 = rx_cnt;
    rx_exp_q.push_back(8'h5A);
    rx_exp_q.push_back(8'hC6);
    miso_exp_q.push_back(8'h11);
    miso_exp_q.push_back(8'h22);
    miso_stable_ok = 1'b1;
    ss_assert(1'b0, 1'b0);
    check("b2b_ready_after_start", tx_ready, 1);
    load_tx(8'h22);
    check("b2b_ready_after_load2", tx_ready, 0);
    xfer(16, 16'h5AC6, got16);
    ss_release();
    check("b2b_miso_first", got16[15:8], miso_exp_q.pop_front());
    check("b2b_miso_second", got16[7:0], miso_exp_q.pop_front());
    check("b2b_rx_pulses", rx_cnt - rx0, 2);
    check("b2b_miso_stable", miso_stable_ok, 1);

    // Underrun: holding empty, MISO all zeros, rx still valid
    check("under_ready", tx_ready, 1);
    full_frame(1'b0, 1'b0, 8'h96, 8'h00, "under");

    // Abort after 5 bits
    load_tx(8'hFF);
    rx0 = rx_cnt;
    ss_assert(1'b0, 1'b0);
    xfer(5, 16'h0015, got16);
    SS_n = 1'b1;
    clks(SYNC);
    check("abort_busy_still", busy, 1);
    clks(1);
    check("abort_busy", busy, 0);
    check("abort_oe", MISO_oe, 0);
    clks(HP);
    check("abort_no_rx", rx_cnt - rx0, 0);
    load_tx(8'h3C);
    full_frame(1'b0, 1'b0, 8'hC3, 8'h3C, "post_abort");

    // Reset mid-frame with a full holding register
    load_tx(8'h55);
    ss_assert(1'b0, 1'b0);
    load_tx(8'h77);
    check("mid_ready_full", tx_ready, 0);
    xfer(3, 16'h0005, got16);
    rst = 1'b1;
    SS_n = 1'b1;
    SCK_in = 1'b0;
    clks(1);
    check("midrst_miso", MISO, 0);
    check("midrst_oe", MISO_oe, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    clks(SYNC + 2);
    rst = 1'b0;
    clks(2);
    // Holding register was cleared by reset: next frame sends zeros
    full_frame(1'b0, 1'b1, 8'hE1, 8'h00, "after_rst");

    // tx_load ignored while the holding register is full
    load_tx(8'h0F);
    check("ign_ready0", tx_ready, 0);
    load_tx(8'hF0);
    check("ign_ready_still0", tx_ready, 0);
    full_frame(1'b0, 1'b0, 8'h24, 8'h0F, "ign");

    // SCK edges while deselected
    rx0 = rx_cnt;
    for (int i = 0; i < 2 * W; i++) begin
      MOSI = 1'($urandom_range(0, 1));
      SCK_in = ~SCK_in;
      clks(HP);
    end
    SCK_in = 1'b0;
    clks(4);
    check("idle_edges_no_rx", rx_cnt - rx0, 0);
    check("idle_edges_busy", busy, 0);

    // Random modes and words
    for (int k = 0; k < 4; k++) begin
      md = int'($urandom_range(0, 3));
      rt = W'($urandom_range(0, 255));
      rm = W'($urandom_range(0, 255));
      load_tx(rt);
      full_frame(md[1], md[0], rm, rt, "rand");
    end

    check("rx_queue_drained", rx_exp_q.size(), 0);
    check("miso_queue_drained", miso_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
